tone_sequencer: RTL and testbench

//  Sequences playback of four 8-bit sample ROMs (one tone segment each) in round-robin order.

---
 rtl/tone_sequencer_if.sv | 34 +++
 rtl/tone_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_tone_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// rtl/tone_sequencer_if.sv - ROM read bus and sample stream between tone_sequencer and its ROMs / audio stage
//
// Purpose: bundles the ROM address/select, the four ROM read-data buses and the
// registered sample stream so the sequencer, the ROMs and the output stage share one port.
// Signals:
//   rom_addr     sequencer -> ROMs   8  ROM address
//   rom_sel      sequencer -> ROMs   2  channel currently addressed
//   rom_data0..3 ROMs -> sequencer   8  ROM read data per channel
//   sample_out   sequencer -> audio  8  output sample
//   sample_valid sequencer -> audio  1  sample_out is new this cycle
//   seg_start    sequencer -> audio  1  first address of a segment issued
// Modports: master = sequencer side, slave = ROM / audio side.

interface tone_sequencer_if;
  logic [7:0] rom_addr;
  logic [1:0] rom_sel;
  logic [7:0] rom_data0;
  logic [7:0] rom_data1;
  logic [7:0] rom_data2;
  logic [7:0] rom_data3;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       seg_start;

  modport master (
    output rom_addr, rom_sel, sample_out, sample_valid, seg_start,
    input  rom_data0, rom_data1, rom_data2, rom_data3
  );

  modport slave (
    input  rom_addr, rom_sel, sample_out, sample_valid, seg_start,
    output rom_data0, rom_data1, rom_data2, rom_data3
  );
endinterface

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - round-robin sequencer for four 8-bit tone sample ROMs
//
// Purpose: divides clk down to the sample rate, walks each enabled channel's ROM
// from address 0 to LENn-1 in round-robin order and returns the ROM words as a
// registered sample stream ROM_LAT cycles after each address issue.
// Ports:
//   clk_i      in   system clock, rising edge
//   rst_i      in   synchronous reset, active-high
//   run_i      in   1 = play, 0 = synchronous clear to idle
//   skip_en_i  in   1 = skip disabled channels, 0 = play them as silence
//   ch_en_i    in   per-channel enable, bit N = channel N
//   bus        --   tone_sequencer_if.master (ROM address/data, sample stream)
//   busy_o     out  1 while playing

module tone_sequencer #(
  parameter int CLK_DIV = 11,
  parameter int LEN0    = 121,
  parameter int LEN1    = 110,
  parameter int LEN2    = 77,
  parameter int LEN3    = 44,
  parameter int ROM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              skip_en_i,
  input  logic [3:0]        ch_en_i,
  tone_sequencer_if.master  bus,
  output logic              busy_o
);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 16 || ROM_LAT < 1 || ROM_LAT > 3 || CLK_DIV <= ROM_LAT ||
        LEN0 < 1 || LEN0 > 256 || LEN1 < 1 || LEN1 > 256 ||
        LEN2 < 1 || LEN2 > 256 || LEN3 < 1 || LEN3 > 256) begin : g_bad_params
      $error("tone_sequencer: illegal parameter combination");
    end
  endgenerate

  typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic [1:0] rom_sel_q, rom_sel_d;
  logic       seg_start_q, seg_start_d;
  logic [7:0] sample_q, sample_d;
  logic       sample_valid_q, sample_valid_d;
  logic       issue;

  // Token = {valid, mute, sel}; one stage per cycle of ROM latency.
  logic [3:0] tok_q [ROM_LAT];
  logic [3:0] tok_in;
  logic [3:0] tok_head;

  logic       clr;
  logic       tick;
  logic [3:0] elig;
  logic       any_elig;
  logic       seg_last;
  logic [7:0] rom_word;

  // First eligible channel among base, base+1, base+2, base+3 (mod 4).
  function automatic logic [1:0] pick_from(input logic [1:0] base, input logic [3:0] el);
    logic [1:0] r;
    r = base;
    for (int i = 3; i >= 0; i--) begin
      if (el[base + 2'(i)]) r = base + 2'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] len_last(input logic [1:0] s);
    case (s)
      2'd0:    return 8'(LEN0 - 1);
      2'd1:    return 8'(LEN1 - 1);
      2'd2:    return 8'(LEN2 - 1);
      default: return 8'(LEN3 - 1);
    endcase
  endfunction

  assign clr      = rst_i | ~run_i;
  assign elig     = ch_en_i | {4{~skip_en_i}};
  assign any_elig = |elig;
  assign seg_last = (rom_addr_q == len_last(rom_sel_q));

  always_comb begin
    tick      = (div_cnt_q == 4'(CLK_DIV - 1));
    div_cnt_d = tick ? 4'd0 : div_cnt_q + 4'd1;
  end

  // State register plus all other address-side registers.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= 4'd0;
      rom_addr_q  <= 8'd0;
      rom_sel_q   <= 2'd0;
      seg_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      rom_addr_q  <= rom_addr_d;
      rom_sel_q   <= rom_sel_d;
      seg_start_q <= seg_start_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: if (any_elig) state_d = ST_PLAY;
        ST_PLAY: if (seg_last && !any_elig) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: address issue, channel advance, segment strobe, busy.
  always_comb begin
    rom_addr_d  = rom_addr_q;
    rom_sel_d   = rom_sel_q;
    seg_start_d = 1'b0;
    issue       = 1'b0;
    busy_o      = (state_q == ST_PLAY);
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            rom_sel_d   = pick_from(2'd0, elig);
            rom_addr_d  = 8'd0;
            seg_start_d = 1'b1;
            issue       = 1'b1;
          end
        end
        ST_PLAY: begin
          if (seg_last) begin
            // With nothing eligible the FSM drops to idle and address state is simply held.
            if (any_elig) begin
              rom_sel_d   = pick_from(rom_sel_q + 2'd1, elig);
              rom_addr_d  = 8'd0;
              seg_start_d = 1'b1;
              issue       = 1'b1;
            end
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            issue      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Mute is decided from the enable switch at issue time, so a channel switched
  // off mid-segment keeps its timing but outputs zeros.
  assign tok_in   = {issue, ~ch_en_i[rom_sel_d], rom_sel_d};
  assign tok_head = tok_q[ROM_LAT-1];

  always_ff @(posedge clk_i) begin
    if (clr) begin
      for (int i = 0; i < ROM_LAT; i++) tok_q[i] <= 4'd0;
    end else begin
      tok_q[0] <= tok_in;
      for (int i = 1; i < ROM_LAT; i++) tok_q[i] <= tok_q[i-1];
    end
  end

  always_comb begin
    case (tok_head[1:0])
      2'd0:    rom_word = bus.rom_data0;
      2'd1:    rom_word = bus.rom_data1;
      2'd2:    rom_word = bus.rom_data2;
      default: rom_word = bus.rom_data3;
    endcase
    sample_valid_d = tok_head[3];
    sample_d       = sample_q;
    if (tok_head[3]) sample_d = tok_head[2] ? 8'd0 : rom_word;
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      sample_q       <= 8'd0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.rom_sel      = rom_sel_q;
  assign bus.seg_start    = seg_start_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer with a sample scoreboard

module tb_tone_sequencer;
  localparam int CLK_DIV = 11;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       skip_en;
  logic [3:0] ch_en;
  logic       busy;
  logic       busy_b;
  logic [3:0] ch_en_b;
  logic       skip_b;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       chk_on;

  exp_t       exq[$];
  int         m_cnt;
  logic       m_play;
  logic [7:0] e_addr;
  logic [1:0] e_sel;
  logic       e_seg;
  logic       e_busy;
  logic       m_clr;
  logic [7:0] m_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tone_sequencer_if bus_a ();
  tone_sequencer_if bus_b ();

  assign bus_a.rom_data0 = bus_a.rom_addr ^ 8'd0;
  assign bus_a.rom_data1 = bus_a.rom_addr ^ 8'd1;
  assign bus_a.rom_data2 = bus_a.rom_addr ^ 8'd2;
  assign bus_a.rom_data3 = bus_a.rom_addr ^ 8'd3;

  assign bus_b.rom_data0 = 8'hA5;
  assign bus_b.rom_data1 = 8'h11;
  assign bus_b.rom_data2 = 8'h22;
  assign bus_b.rom_data3 = 8'h33;
  assign ch_en_b = 4'b0001;
  assign skip_b  = 1'b1;

  tone_sequencer u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .run_i     (run),
    .skip_en_i (skip_en),
    .ch_en_i   (ch_en),
    .bus       (bus_a),
    .busy_o    (busy)
  );

  tone_sequencer #(.CLK_DIV(2), .LEN0(1), .ROM_LAT(1)) u_dut_short (
    .clk_i     (clk),
    .rst_i     (rst),
    .run_i     (run),
    .skip_en_i (skip_b),
    .ch_en_i   (ch_en_b),
    .bus       (bus_b),
    .busy_o    (busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int len_of(input logic [1:0] s);
    case (s)
      2'd0:    return 121;
      2'd1:    return 110;
      2'd2:    return 77;
      default: return 44;
    endcase
  endfunction

  // First eligible channel after c, wrapping round to c itself.
  function automatic logic [1:0] next_f(input int c, input logic [3:0] el);
    for (int k = 1; k <= 4; k++) begin
      if (el[(c + k) % 4]) return 2'((c + k) % 4);
    end
    return 2'(c);
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] s, input logic [7:0] a);
    exp_t x;
    x.sel  = s;
    x.data = ch_en[s] ? (a ^ {6'd0, s}) : 8'h00;
    x.due  = cyc + 2;
    return x;
  endfunction

  // Reference model: predicts address-side outputs per cycle and queues expected samples.
  always @(posedge clk) begin
    m_clr <= rst || !run;
    if (rst || !run) begin
      m_cnt  <= 0;
      m_play <= 1'b0;
      e_addr <= 8'd0;
      e_sel  <= 2'd0;
      e_seg  <= 1'b0;
      e_busy <= 1'b0;
      exq.delete();
    end else begin
      m_cnt <= (m_cnt == CLK_DIV - 1) ? 0 : m_cnt + 1;
      e_seg <= 1'b0;
      if (m_cnt == CLK_DIV - 1) begin
        if (!m_play) begin
          if ((ch_en | {4{~skip_en}}) != 4'd0) begin
            m_play <= 1'b1;
            e_busy <= 1'b1;
            e_sel  <= next_f(3, ch_en | {4{~skip_en}});
            e_addr <= 8'd0;
            e_seg  <= 1'b1;
            exq.push_back(mk_exp(next_f(3, ch_en | {4{~skip_en}}), 8'd0));
          end
        end else if (int'(e_addr) == len_of(e_sel) - 1) begin
          if ((ch_en | {4{~skip_en}}) != 4'd0) begin
            e_sel  <= next_f(int'(e_sel), ch_en | {4{~skip_en}});
            e_addr <= 8'd0;
            e_seg  <= 1'b1;
            exq.push_back(mk_exp(next_f(int'(e_sel), ch_en | {4{~skip_en}}), 8'd0));
          end else begin
            m_play <= 1'b0;
            e_busy <= 1'b0;
          end
        end else begin
          e_addr <= e_addr + 8'd1;
          exq.push_back(mk_exp(e_sel, e_addr + 8'd1));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("addr_side", {busy, bus_a.seg_start, bus_a.rom_sel, bus_a.rom_addr},
               {e_busy, e_seg, e_sel, e_addr});
      if (bus_a.sample_valid) begin
        if (exq.size() == 0) begin
          check_eq("spurious_valid", bus_a.sample_valid, 1'b0);
        end else begin
          check_eq("sample", {bus_a.rom_sel, bus_a.sample_out}, {exq[0].sel, exq[0].data});
          check_eq("latency", cyc, exq[0].due);
          m_last <= exq[0].data;
          exq.delete(0);
        end
      end else begin
        check_eq("hold", bus_a.sample_out, m_clr ? 8'd0 : m_last);
        if (exq.size() != 0 && exq[0].due <= cyc) check_eq("missing_valid", bus_a.sample_valid, 1'b1);
        if (m_clr) m_last <= 8'd0;
      end
    end
  end

  task automatic wait_pos(input logic [1:0] s, input logic [7:0] a, input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (e_busy && e_sel == s && e_addr == a) found = 1'b1;
    end
  endtask

  task automatic restart_check(input string tag);
    int k;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(posedge clk); #1;
      if (bus_a.seg_start) k = i;
    end
    check_eq(tag, {k[7:0], bus_a.rom_sel, bus_a.rom_addr}, {8'd11, 2'd0, 8'd0});
  endtask

  initial begin
    int   first_seg;
    int   bad;
    int   cnt;
    logic found;

    rst = 1'b1; run = 1'b0; ch_en = 4'h0; skip_en = 1'b0; chk_on = 1'b0; m_last = 8'd0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", {busy, bus_a.seg_start, bus_a.rom_sel, bus_a.rom_addr,
                             bus_a.sample_out, bus_a.sample_valid}, 32'd0);

    // 1/6: all channels, first segment timing; short instance runs alongside.
    rst = 1'b0; run = 1'b1; ch_en = 4'hF; skip_en = 1'b0;
    first_seg = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus_a.seg_start && first_seg == 0) first_seg = k;
      check_eq("short_seg", bus_b.seg_start, (k >= 2 && k % 2 == 0));
      check_eq("short_valid", bus_b.sample_valid, (k >= 3 && k % 2 == 1));
      check_eq("short_addr", bus_b.rom_addr, 8'd0);
      if (k >= 3) check_eq("short_sample", bus_b.sample_out, 8'hA5);
    end
    check_eq("first_seg_cycle", first_seg, 11);
    repeat (3900) @(posedge clk);

    // 2: channel 2 disabled but played as silence.
    #1 ch_en = 4'b1011;
    repeat (4000) @(posedge clk);

    // 3: skip disabled channels; only 0 and 2 may start segments.
    #1 ch_en = 4'b0101; skip_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (bus_a.seg_start && bus_a.rom_sel[0]) bad++;
    end
    check_eq("odd_sel_started", bad, 0);

    // 4: disable everything mid-segment 0; segment must run to completion.
    wait_pos(2'd0, 8'd10, 4000, found);
    check_eq("reach_sel0_addr10", found, 1'b1);
    ch_en = 4'h0;
    cnt = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      @(posedge clk); #1;
      if (bus_a.sample_valid) cnt++;
    end
    check_eq("tail_samples", cnt, 111);
    repeat (30) @(posedge clk);
    #1;
    check_eq("idle_busy", busy, 1'b0);
    ch_en = 4'b1000;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (bus_a.seg_start) found = 1'b1;
    end
    check_eq("resume_sel3", {found, bus_a.rom_sel, bus_a.rom_addr}, {1'b1, 2'd3, 8'd0});

    // 5: reset, then run=0, at sel 1 addr 60.
    ch_en = 4'hF; skip_en = 1'b0;
    wait_pos(2'd1, 8'd60, 6000, found);
    check_eq("reach_sel1_addr60_a", found, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_clears", {busy, bus_a.seg_start, bus_a.rom_sel, bus_a.rom_addr,
                            bus_a.sample_out, bus_a.sample_valid}, 32'd0);
    rst = 1'b0;
    restart_check("restart_after_rst");

    wait_pos(2'd1, 8'd60, 6000, found);
    check_eq("reach_sel1_addr60_b", found, 1'b1);
    run = 1'b0;
    @(posedge clk); #1;
    check_eq("run0_clears", {busy, bus_a.seg_start, bus_a.rom_sel, bus_a.rom_addr,
                             bus_a.sample_out, bus_a.sample_valid}, 32'd0);
    run = 1'b1;
    restart_check("restart_after_run0");
    repeat (200) @(posedge clk);

    #1 run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("queue_drained", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
